// File: rtl/instruction_encoder_pkg.sv
// instruction_encoder_pkg: shared opcode constants, request kinds and encoder FSM states
package instruction_encoder_pkg;
  typedef enum logic [1:0] {
    KIND_R    = 2'd0,
    KIND_LUI  = 2'd1,
    KIND_ADDI = 2'd2,
    KIND_ORI  = 2'd3
  } kind_e;
  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_e;
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ORI    = 6'h0D;
endpackage

// File: rtl/instruction_encoder_instr_pack.sv
// instr_pack: packs request fields into a 32-bit MIPS-style instruction word
// kind_i selects the format; rs_i/rt_i/rd_i/shamt_i/funct_i/imm_i are raw fields; word_o is the packed word.
// Fields a format does not use are simply left out of the concatenation.
module instr_pack
  import instruction_encoder_pkg::*;
(
  input  logic [1:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o
);
  always_comb
    word_o = kind_i == KIND_R   ? {OP_R_TYPE, rs_i, rt_i, rd_i, shamt_i, funct_i}
           : kind_i == KIND_LUI ? {OP_LUI, 5'd0, rt_i, imm_i}
           : {kind_i == KIND_ADDI ? OP_ADDI : OP_ORI, rs_i, rt_i, imm_i};
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: accepts encode requests and writes packed words to sequential instruction-memory addresses
// clk/reset: clock and async active-high reset; clear_i: sync restart of pointer and count.
// req_valid_i/req_ready_o + kind_i and field inputs: request handshake.
// mem_write_o/mem_addr_o/mem_data_o/mem_ack_i: memory write port held until acked.
// count_o/full_o: words written so far and the DEPTH-reached flag.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int          DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack_i,
  output logic [6:0]  count_o,
  output logic        full_o
);
  localparam logic [6:0] DEPTH_C = 7'(DEPTH);
  state_e      state_q;
  logic [31:0] addr_q, addr_d, data_q, word;
  logic [6:0]  count_q, count_d;
  logic        ready_q, write_q, full_q;
  instr_pack u_pack (
    .kind_i  (kind_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .rd_i    (rd_i),
    .shamt_i (shamt_i),
    .funct_i (funct_i),
    .imm_i   (imm_i),
    .word_o  (word)
  );
  always_comb begin
    addr_d  = addr_q + 32'd4;
    count_d = count_q == DEPTH_C ? count_q : count_q + 7'd1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      write_q <= 1'b0;
      full_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      ready_q <= 1'b1;
      write_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          data_q  <= word;
          state_q <= WRITE;
          ready_q <= 1'b0;
          write_q <= 1'b1;
        end
        WRITE: if (mem_ack_i) begin
          addr_q  <= addr_d;
          count_q <= count_d;
          state_q <= count_d == DEPTH_C ? FULL : IDLE;
          ready_q <= count_d != DEPTH_C;
          full_q  <= count_d == DEPTH_C;
          write_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
  assign req_ready_o = ready_q;
  assign mem_write_o = write_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign count_o     = count_q;
  assign full_o      = full_q;
endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h0040_0000, byte address of first instruction word written.
REQ-002 SHALL provide parameter DEPTH, default 64, maximum number of words written before full.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port clear_i  input  1  synchronous restart: pointer to BASE_ADDR, count to 0.
REQ-006 SHALL provide port req_valid_i  input  1  request present.
REQ-007 SHALL provide port req_ready_o  output  1  request accepted when valid and ready are both high.
REQ-008 SHALL provide port kind_i  input  2  0=R-type, 1=LUI, 2=ADDI, 3=ORI.
REQ-009 SHALL provide ports rs_i, rt_i, rd_i, shamt_i  input  5 each  register and shift fields.
REQ-010 SHALL provide ports funct_i  input  6 and imm_i  input  16  function code and immediate.
REQ-011 SHALL provide port mem_write_o  output  1  instruction-memory write strobe.
REQ-012 SHALL provide port mem_addr_o  output  32  byte address of the write.
REQ-013 SHALL provide port mem_data_o  output  32  encoded instruction word.
REQ-014 SHALL provide port mem_ack_i  input  1  memory has taken the current write.
REQ-015 SHALL provide ports count_o  output  7 (words written) and full_o  output  1.

Function
REQ-016 Encoding SHALL be: R-type {6'h00,rs,rt,rd,shamt,funct}; LUI {6'h0F,5'd0,rt,imm}; ADDI {6'h08,rs,rt,imm}; ORI {6'h0D,rs,rt,imm}.
REQ-017 FSM states SHALL be IDLE, WRITE, FULL.
REQ-018 IDLE: req_ready_o=1; on accept, the word is registered into mem_data_o and the state goes to WRITE on the next edge.
REQ-019 WRITE: mem_write_o=1, req_ready_o=0; mem_addr_o and mem_data_o held stable until mem_ack_i=1.
REQ-020 On mem_ack_i in WRITE: pointer += 4, count += 1; next state FULL if the new count equals DEPTH, else IDLE.
REQ-021 Latency SHALL be one cycle: a request accepted at edge N yields mem_write_o=1 from N+1 onward.
REQ-022 Ack in the first WRITE cycle SHALL permit a new accept on the following cycle (one word per two cycles peak).
REQ-023 FULL: req_ready_o=0, mem_write_o=0, full_o=1; leave only via clear_i or reset.
REQ-024 clear_i SHALL dominate req_valid_i and mem_ack_i in the same cycle; in-flight write is abandoned, state goes to IDLE.
REQ-025 mem_ack_i outside WRITE SHALL be ignored.
REQ-026 Pointer arithmetic SHALL be 32-bit unsigned; count saturates at DEPTH and never wraps.
REQ-027 Unused fields per kind (rd, shamt, funct for I-types; imm for R-type; rs for LUI) SHALL be ignored.

Reset
REQ-028 On reset: state IDLE, mem_addr_o=BASE_ADDR, mem_data_o=0, mem_write_o=0, count_o=0, full_o=0, req_ready_o=1 after release.
REQ-029 Reset asserted mid-WRITE SHALL drop mem_write_o immediately (asynchronously) and discard the word.

Structure
REQ-030 Opcode constants (R_TYPE 6'h00, LUI 6'h0F, ADDI 6'h08, ORI 6'h0D) and kind encodings SHALL live in a shared package also used by the control decoder.
REQ-031 Pure field packing SHALL be a combinational sub-module instr_pack; FSM, pointer and count stay in instruction_encoder.

Verification
REQ-032 ADDI rs=0 rt=8 imm=5 with immediate ack -> mem_write_o one cycle later, data 32'h20080005, addr 32'h00400000.
REQ-033 Sequence LUI rt=1 imm=16'h1001; ORI rs=1 rt=9 imm=16'h00FF; R rs=8 rt=9 rd=10 funct=6'h20 -> data 3C011001, 342900FF, 01095020 at addresses 00400000, 00400004, 00400008; count_o=3.
REQ-034 Ack withheld 5 cycles -> mem_write_o, addr and data stable for 6 cycles, req_ready_o=0 throughout, a single increment.
REQ-035 DEPTH=4, four acked writes -> full_o=1, req_ready_o=0, further valid ignored; clear_i -> IDLE, addr 00400000, count 0.
REQ-036 clear_i together with mem_ack_i in WRITE -> count unchanged at 0, pointer BASE_ADDR; reset pulse mid-WRITE -> mem_write_o low the same cycle.
